// File: rtl/inv_cipher_stream_if.sv
// inv_cipher_stream_if: 32-bit stream front/back end for a combinational
// 128-bit inverse cipher. It collects four ciphertext words, holds the block
// on o_block while the decryptor settles, then streams out four plaintext words.
// Ports:
//   i_clk, i_rst_n          clock, async active-low reset
//   i_word/i_valid/o_ready  ciphertext word stream in
//   o_block                 assembled ciphertext to decryptor i_data
//   i_plain                 decryptor o_data
//   o_word/o_valid/i_ready  plaintext word stream out
//   o_busy                  block in flight (partial, settling or draining)
module inv_cipher_stream_if #(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic [31:0]  i_word,
    input  logic         i_valid,
    output logic         o_ready,
    output logic [127:0] o_block,
    input  logic [127:0] i_plain,
    output logic [31:0]  o_word,
    output logic         o_valid,
    input  logic         i_ready,
    output logic         o_busy
);
    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        SETTLE  = 2'd1,
        DRAIN   = 2'd2
    } state_t;

    localparam logic [3:0] SETTLE_INIT = 4'(SETTLE_CYCLES);

    state_t       r_state;
    state_t       w_next;
    logic [1:0]   r_cnt;
    logic [1:0]   r_idx;
    logic [3:0]   r_settle;
    logic [127:0] r_block;
    logic [127:0] r_out;
    logic         w_in_fire;
    logic         w_out_fire;
    logic         w_settle_done;

    assign w_in_fire     = (r_state == COLLECT) && i_valid;
    assign w_out_fire    = (r_state == DRAIN) && i_ready;
    assign w_settle_done = (r_state == SETTLE) && (r_settle == 4'd1);
    assign o_block       = r_block;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= COLLECT;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next  = r_state;
        o_ready = 1'b0;
        o_valid = 1'b0;
        o_word  = 32'd0;
        o_busy  = (r_state != COLLECT) || (r_cnt != 2'd0);
        case (r_state)
            COLLECT: begin
                o_ready = 1'b1;
                if (w_in_fire && (r_cnt == 2'd3)) begin
                    w_next = SETTLE;
                end
            end
            SETTLE: begin
                if (w_settle_done) begin
                    w_next = DRAIN;
                end
            end
            DRAIN: begin
                o_valid = 1'b1;
                case (r_idx)
                    2'd0:    o_word = r_out[127:96];
                    2'd1:    o_word = r_out[95:64];
                    2'd2:    o_word = r_out[63:32];
                    default: o_word = r_out[31:0];
                endcase
                if (w_out_fire && (r_idx == 2'd3)) begin
                    w_next = COLLECT;
                end
            end
            default: w_next = COLLECT;
        endcase
    end

    // Datapath: word count wraps to 0 naturally after the 4th word.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt    <= 2'd0;
            r_idx    <= 2'd0;
            r_settle <= 4'd0;
            r_block  <= 128'd0;
            r_out    <= 128'd0;
        end else begin
            if (w_in_fire) begin
                r_cnt <= r_cnt + 2'd1;
                case (r_cnt)
                    2'd0:    r_block[127:96] <= i_word;
                    2'd1:    r_block[95:64]  <= i_word;
                    2'd2:    r_block[63:32]  <= i_word;
                    default: r_block[31:0]   <= i_word;
                endcase
                if (r_cnt == 2'd3) begin
                    r_settle <= SETTLE_INIT;
                end
            end
            if (r_state == SETTLE) begin
                r_settle <= r_settle - 4'd1;
                if (w_settle_done) begin
                    r_out <= i_plain;
                end
            end
            if (w_out_fire) begin
                r_idx <= r_idx + 2'd1;
            end
        end
    end

endmodule

// File: tb/tb_inv_cipher_stream_if.sv
// tb_inv_cipher_stream_if: randomized self-checking bench for three builds
// (SETTLE_CYCLES = 2, 1, 15) driven against a slow behavioural decryptor.
module tb_inv_cipher_stream_if;
    localparam logic [127:0] KCT = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] KPT = 128'h00112233445566778899aabbccddeeff;

    logic         clk = 1'b0;
    logic         rst_n    [3];
    logic         valid    [3];
    logic         ready_in [3];
    logic         oready   [3];
    logic         ovalid   [3];
    logic         busy     [3];
    logic [31:0]  word     [3];
    logic [31:0]  oword    [3];
    logic [127:0] blk      [3];
    logic [127:0] plain    [3];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    function automatic int sc(input int k);
        return (k == 0) ? 2 : ((k == 1) ? 1 : 15);
    endfunction

    // Stand-in for the AES-128 inverse cipher: exact on the known vector,
    // an arbitrary bijection elsewhere.
    function automatic logic [127:0] fake_dec(input logic [127:0] c);
        if (c == KCT) return KPT;
        return {c[95:0], c[127:96]} ^ 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;
    endfunction

    // Decryptor output is only trustworthy once its input has been stable
    // for SETTLE-1 full cycles; before that it shows wrong data.
    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int S = (g == 0) ? 2 : ((g == 1) ? 1 : 15);
        int           stab  = 0;
        logic [127:0] prevb = '0;
        always @(negedge clk) begin
            if (blk[g] !== prevb) begin
                prevb = blk[g];
                stab  = 0;
            end else begin
                stab = stab + 1;
            end
        end
        assign plain[g] = (stab >= S - 1) ? fake_dec(blk[g]) : ~fake_dec(blk[g]);
        inv_cipher_stream_if #(.SETTLE_CYCLES(S)) u_dut (
            .i_clk   (clk),
            .i_rst_n (rst_n[g]),
            .i_word  (word[g]),
            .i_valid (valid[g]),
            .o_ready (oready[g]),
            .o_block (blk[g]),
            .i_plain (plain[g]),
            .o_word  (oword[g]),
            .o_valid (ovalid[g]),
            .i_ready (ready_in[g]),
            .o_busy  (busy[g])
        );
    end

    // Runs one block through instance k. Returns at 1 time unit after the
    // edge of the last requested output transfer.
    task automatic do_block(input int k, input logic [127:0] ct,
                            input int lowpct, input bit junk, input int nout);
        logic [127:0] pt;
        int n;
        int cyc;
        int lat;
        int got;
        bit fire;
        bit rdy;
        pt  = fake_dec(ct);
        n   = 0;
        cyc = 0;
        while (n < 4 && cyc < 100) begin
            word[k]  = ct[127-32*n -: 32];
            valid[k] = ($urandom_range(99) >= lowpct / 2);
            fire     = valid[k] && oready[k];
            @(posedge clk); #1;
            cyc++;
            if (fire) n++;
        end
        n_checks++;
        if (n != 4) begin
            n_fail++;
            $display("FAIL in_timeout k=%0d words %0d want 4", k, n);
        end
        if (lowpct == 0) begin
            n_checks++;
            if (cyc != 4) begin
                n_fail++;
                $display("FAIL in_cycles k=%0d got %0d want 4", k, cyc);
            end
        end
        valid[k] = junk;
        word[k]  = $urandom;
        lat = 0;
        while (!ovalid[k] && lat < 40) begin
            n_checks++;
            if (oready[k] !== 1'b0 || busy[k] !== 1'b1) begin
                n_fail++;
                $display("FAIL settle_flags k=%0d ready %b busy %b want 0 1",
                         k, oready[k], busy[k]);
            end
            @(posedge clk); #1;
            lat++;
            if (junk) word[k] = $urandom;
        end
        n_checks++;
        if (lat != sc(k)) begin
            n_fail++;
            $display("FAIL latency k=%0d got %0d want %0d", k, lat, sc(k));
        end
        n_checks++;
        if (blk[k] !== ct) begin
            n_fail++;
            $display("FAIL o_block k=%0d got %h want %h", k, blk[k], ct);
        end
        got = 0;
        cyc = 0;
        while (got < nout && cyc < 300) begin
            n_checks++;
            if (ovalid[k] !== 1'b1 || oready[k] !== 1'b0 ||
                oword[k] !== pt[127-32*got -: 32]) begin
                n_fail++;
                $display("FAIL drain_word k=%0d idx %0d valid %b ready %b got %h want %h",
                         k, got, ovalid[k], oready[k], oword[k], pt[127-32*got -: 32]);
            end
            rdy         = ($urandom_range(99) >= lowpct);
            ready_in[k] = rdy;
            @(posedge clk); #1;
            cyc++;
            if (junk) word[k] = $urandom;
            if (rdy) got++;
        end
        ready_in[k] = 1'b0;
        valid[k]    = 1'b0;
        n_checks++;
        if (got != nout) begin
            n_fail++;
            $display("FAIL out_timeout k=%0d got %0d want %0d", k, got, nout);
        end
        if (nout == 4) begin
            n_checks++;
            if (oready[k] !== 1'b1 || ovalid[k] !== 1'b0 ||
                busy[k] !== 1'b0 || blk[k] !== ct) begin
                n_fail++;
                $display("FAIL after_drain k=%0d ready %b valid %b busy %b blk %h want 1 0 0 %h",
                         k, oready[k], ovalid[k], busy[k], blk[k], ct);
            end
        end
    endtask

    task automatic test_reset;
        for (int k = 0; k < 3; k++) begin
            rst_n[k]    = 1'b0;
            valid[k]    = 1'b0;
            ready_in[k] = 1'b0;
            word[k]     = 32'd0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            n_checks++;
            if (oready[k] !== 1'b1 || ovalid[k] !== 1'b0 || oword[k] !== 32'd0 ||
                busy[k] !== 1'b0 || blk[k] !== 128'd0) begin
                n_fail++;
                $display("FAIL reset_state k=%0d ready %b valid %b word %h busy %b blk %h want 1 0 0 0 0",
                         k, oready[k], ovalid[k], oword[k], busy[k], blk[k]);
            end
            rst_n[k] = 1'b1;
        end
    endtask

    task automatic test_known_vector;
        do_block(0, KCT, 0, 1'b0, 4);
    endtask

    task automatic test_stall;
        do_block(0, KCT, 60, 1'b0, 4);
        do_block(0, {$urandom, $urandom, $urandom, $urandom}, 60, 1'b0, 4);
    endtask

    task automatic test_garbage;
        do_block(0, {$urandom, $urandom, $urandom, $urandom}, 0, 1'b1, 4);
        do_block(0, KCT, 0, 1'b0, 4);
    endtask

    task automatic test_reset_partial;
        logic [127:0] ct;
        ct = {$urandom, $urandom, $urandom, $urandom};
        for (int i = 0; i < 2; i++) begin
            word[0]  = ct[127-32*i -: 32];
            valid[0] = 1'b1;
            @(posedge clk); #1;
        end
        valid[0] = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        n_checks++;
        if (busy[0] !== 1'b1 || blk[0][127:64] !== ct[127:64] || oready[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL partial_hold busy %b ready %b blk %h want 1 1 %h",
                     busy[0], oready[0], blk[0][127:64], ct[127:64]);
        end
        #2 rst_n[0] = 1'b0;
        #1;
        n_checks++;
        if (busy[0] !== 1'b0 || blk[0] !== 128'd0) begin
            n_fail++;
            $display("FAIL partial_reset busy %b blk %h want 0 0", busy[0], blk[0]);
        end
        @(posedge clk); #1;
        rst_n[0] = 1'b1;
        do_block(0, KCT, 0, 1'b0, 4);
    endtask

    task automatic test_reset_drain;
        do_block(0, {$urandom, $urandom, $urandom, $urandom}, 0, 1'b0, 1);
        #2 rst_n[0] = 1'b0;
        #1;
        n_checks++;
        if (ovalid[0] !== 1'b0 || oready[0] !== 1'b1 ||
            busy[0] !== 1'b0 || oword[0] !== 32'd0) begin
            n_fail++;
            $display("FAIL drain_reset valid %b ready %b busy %b word %h want 0 1 0 0",
                     ovalid[0], oready[0], busy[0], oword[0]);
        end
        @(posedge clk); #1;
        rst_n[0]    = 1'b1;
        ready_in[0] = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (ovalid[0] !== 1'b0 || busy[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL stale_after_reset valid %b busy %b want 0 0", ovalid[0], busy[0]);
        end
        ready_in[0] = 1'b0;
        do_block(0, KCT, 0, 1'b0, 4);
    endtask

    task automatic test_back_to_back;
        for (int k = 1; k < 3; k++) begin
            do_block(k, KCT, 0, 1'b0, 4);
            for (int b = 0; b < 2; b++) begin
                do_block(k, {$urandom, $urandom, $urandom, $urandom}, 0, 1'b0, 4);
            end
        end
        for (int b = 0; b < 3; b++) begin
            do_block(0, {$urandom, $urandom, $urandom, $urandom}, 0, 1'b0, 4);
        end
    endtask

    initial begin
        test_reset;
        test_known_vector;
        test_stall;
        test_garbage;
        test_reset_partial;
        test_reset_drain;
        test_back_to_back;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/inv_cipher_stream_if.md
INV_CIPHER_STREAM_IF -- requirements
Module: inv_cipher_stream_if

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, default 2, giving the number of clock cycles allowed for the combinational decryptor to settle (legal range 1..15).
REQ-002 SHALL have port i_clk, input, 1, sole clock; all state updates on its rising edge.
REQ-003 SHALL have port i_rst_n, input, 1, reset that is asynchronous and active-low.
REQ-004 SHALL have port i_word, input, 32, ciphertext word.
REQ-005 SHALL have port i_valid, input, 1, i_word valid.
REQ-006 SHALL have port o_ready, output, 1, block accepts i_word.
REQ-007 SHALL have port o_block, output, 128, assembled ciphertext, driven to decryptor i_data.
REQ-008 SHALL have port i_plain, input, 128, decryptor o_data.
REQ-009 SHALL have port o_word, output, 32, plaintext word.
REQ-010 SHALL have port o_valid, output, 1, o_word valid.
REQ-011 SHALL have port i_ready, input, 1, sink accepts o_word.
REQ-012 SHALL have port o_busy, output, 1, high whenever state is not COLLECT or the input word count is nonzero.

Function
REQ-013 SHALL implement FSM states COLLECT, SETTLE, DRAIN.
REQ-014 COLLECT: o_ready=1, o_valid=0; a word transfers when i_valid&o_ready; the first word of a block goes to o_block[127:96], then [95:64], [63:32], [31:0].
REQ-015 SHALL hold a 2-bit input word count; after the 4th transfer, reset the count to 0, load the settle counter with SETTLE_CYCLES and go to SETTLE.
REQ-016 o_block SHALL be registered and SHALL change only on accepted input words.
REQ-017 SETTLE: o_ready=0, o_valid=0; decrement the counter each cycle. In the cycle the counter equals 1, capture i_plain into a 128-bit output register and go to DRAIN.
REQ-018 Latency: the 4th input transfer at edge N gives i_plain capture at edge N+SETTLE_CYCLES, with o_valid high from that edge.
REQ-019 DRAIN: o_ready=0, o_valid=1; o_word = output register word selected by a 2-bit output index, index 0 = [127:96].
REQ-020 An output word transfers when o_valid&i_ready and advances the index; after index 3 transfers, clear the index and go to COLLECT.
REQ-021 o_word and o_valid SHALL remain stable while o_valid=1 and i_ready=0, with no dropped or duplicated words.
REQ-022 i_valid SHALL be ignored outside COLLECT; no input is buffered during SETTLE or DRAIN.
REQ-023 i_ready SHALL be ignored outside DRAIN.
REQ-024 A partial input block (count 1..3) SHALL be held indefinitely while i_valid is low.
REQ-025 Back-to-back blocks: the first input word of the next block SHALL be acceptable in the cycle after the 4th output transfer.

Reset
REQ-026 While i_rst_n=0 (asynchronously), the block SHALL go to state COLLECT with word count, output index and settle counter set to 0, o_block=0, output register=0, o_ready=1, o_valid=0, o_word=0, o_busy=0.
REQ-027 Reset asserted mid-COLLECT, SETTLE or DRAIN SHALL discard the partial or pending block, and no stale word SHALL appear after release.
REQ-028 Operation SHALL resume on the first rising edge after i_rst_n deasserts.

Verification
REQ-029 Decryptor NK=4 with key 000102030405060708090a0b0c0d0e0f; feed 69c4e0d8,6a7b0430,d8cdb780,70b4c55a with i_ready=1 -> o_block=69c4e0d86a7b0430d8cdb78070b4c55a; outputs 00112233,44556677,8899aabb,ccddeeff in order; o_valid rises exactly SETTLE_CYCLES edges after the 4th input.
REQ-030 Same vector with i_ready toggled randomly (>=50% low) -> identical 4 words, o_word stable while stalled, exactly 4 transfers.
REQ-031 i_valid held high through SETTLE/DRAIN with distinct garbage words -> o_ready=0 there, garbage not absorbed, the next block decrypts correctly.
REQ-032 Reset pulse after 2 input words, then a full vector -> correct plaintext output, no leftover words.
REQ-033 Reset pulse during DRAIN after 1 output word -> o_valid=0 immediately (async), state COLLECT, o_busy=0.
REQ-034 SETTLE_CYCLES=1 and =15 builds, three back-to-back blocks -> correct output each, latency 1 and 15 respectively, next input accepted the cycle after the last output.
